// File: rtl/mem_access_arbiter_pkg.sv
// mem_pkg: shared FSM state encoding and parameter limits for the memory access blocks.
package mem_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_e;
    localparam int MIN_PORTS = 1;
    localparam int MAX_PORTS = 8;
    localparam int MIN_ACCESS_CYCLES = 1;
    localparam int MAX_ACCESS_CYCLES = 15;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_access_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from last_i+1 modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] idx_o
);
    logic [IW-1:0] c;
    always_comb begin
        win_o = '0;
        idx_o = '0;
        c     = '0;
        // Walk from farthest to nearest so the closest requester after last_i wins.
        for (int i = N; i >= 1; i--) begin
            c = IW'((int'(last_i) + i) % N);
            if (req_i[c]) idx_o = c;
        end
        win_o[idx_o] = |req_i;
    end
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin access to a fixed-latency memory with per-port done pulses.
module mem_access_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int ACCESS_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] done,
    output logic                 ready,
    output logic [CNT_W-1:0]     busy_cnt
);
    localparam int IW = idx_w(NUM_PORTS);

    state_e               state_q;
    logic [NUM_PORTS-1:0] grant_q, done_q, win;
    logic                 ready_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IW-1:0]        last_q, win_idx;

    rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_rr (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (win),
        .idx_o  (win_idx)
    );

    // DONE accepts a new request exactly like IDLE, giving back-to-back accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
            last_q  <= IW'(NUM_PORTS - 1);
        end else if (state_q == BUSY) begin
            if (cnt_q == '0) begin
                state_q <= DONE;
                done_q  <= grant_q;
                ready_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end else if (|req) begin
            state_q <= BUSY;
            grant_q <= win;
            done_q  <= '0;
            ready_q <= 1'b0;
            cnt_q   <= CNT_W'(ACCESS_CYCLES - 1);
            last_q  <= win_idx;
        end else begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            ready_q <= 1'b1;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign ready    = ready_q;
    assign busy_cnt = cnt_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed checks on three configurations sharing clock and reset.
module tb_mem_access_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] reqa = '0, granta, donea;
    logic       readya;
    logic [3:0] cnta;
    logic [3:0] reqb = '0, grantb, doneb;
    logic       readyb;
    logic [3:0] cntb;
    logic [1:0] reqc = '0, grantc, donec;
    logic       readyc;
    logic [3:0] cntc;
    int checks = 0;
    int errors = 0;
    int dcnt[4];
    logic [1:0] eg[9] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    logic [1:0] ed[9] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};

    always #5 clk = ~clk;

    mem_access_arbiter #(.NUM_PORTS(2), .ACCESS_CYCLES(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(reqa), .grant(granta), .done(donea),
        .ready(readya), .busy_cnt(cnta));
    mem_access_arbiter #(.NUM_PORTS(4), .ACCESS_CYCLES(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(reqb), .grant(grantb), .done(doneb),
        .ready(readyb), .busy_cnt(cntb));
    mem_access_arbiter #(.NUM_PORTS(2), .ACCESS_CYCLES(2), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(reqc), .grant(grantc), .done(donec),
        .ready(readyc), .busy_cnt(cntc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) if (doneb[p]) dcnt[p]++;
    endtask

    initial begin
        for (int p = 0; p < 4; p++) dcnt[p] = 0;
        #12;
        chk("rst_ready", readyb, 1);
        chk("rst_grant", grantb, 0);
        chk("rst_done", doneb, 0);
        chk("rst_cnt", cntb, 0);
        rst_n = 1'b1;
        tick;
        // single access latency, ACCESS_CYCLES=1
        reqa = 2'b10;
        tick;
        chk("a_grant", granta, 2'b10);
        chk("a_ready_low", readya, 0);
        chk("a_no_done", donea, 0);
        tick;
        chk("a_done", donea, 2'b10);
        chk("a_ready_high", readya, 1);
        chk("a_grant_in_done", granta, 2'b10);
        reqa = '0;
        tick;
        chk("a_idle_done", donea, 0);
        chk("a_idle_grant", granta, 0);
        // single access latency, ACCESS_CYCLES=4, port 1
        reqb = 4'b0010;
        tick;
        chk("b_grant", grantb, 4'b0010);
        chk("b_ready_low", readyb, 0);
        chk("b_cnt_load", cntb, 3);
        for (int j = 1; j <= 3; j++) begin
            tick;
            chk("b_busy_ready", readyb, 0);
            chk("b_busy_cnt", cntb, 3 - j);
            chk("b_busy_done", doneb, 0);
        end
        tick;
        chk("b_done", doneb, 4'b0010);
        chk("b_ready_high", readyb, 1);
        reqb = '0;
        tick;
        chk("b_done_once", doneb, 0);
        // contention with ACCESS_CYCLES=2, then back-to-back on port 0
        reqc = 2'b11;
        for (int i = 0; i < 9; i++) begin
            tick;
            chk("c_rr_grant", grantc, eg[i]);
            chk("c_rr_done", donec, ed[i]);
        end
        reqc = 2'b01;
        tick;
        chk("c_b2b_grant", grantc, 2'b01);
        chk("c_b2b_ready", readyc, 0);
        chk("c_b2b_done", donec, 0);
        tick;
        tick;
        chk("c_b2b_done2", donec, 2'b01);
        reqc = '0;
        tick;
        chk("c_idle_grant", grantc, 0);
        chk("c_idle_ready", readyc, 1);
        // early release on port 0
        reqb = 4'b0001;
        tick;
        chk("e_grant", grantb, 4'b0001);
        reqb = '0;
        for (int j = 1; j <= 3; j++) begin
            tick;
            chk("e_busy_done", doneb, 0);
            chk("e_grant_held", grantb, 4'b0001);
        end
        tick;
        chk("e_done", doneb, 4'b0001);
        tick;
        chk("e_done_once", doneb, 0);
        chk("e_idle_grant", grantb, 0);
        // staggered requests on four ports, pointer left at 2
        reqb = 4'b0100;
        tick;
        chk("s_grant2", grantb, 4'b0100);
        reqb = 4'b1100;
        tick;
        reqb = 4'b1110;
        tick;
        tick;
        tick;
        chk("s_done2", doneb, 4'b0100);
        for (int p = 0; p < 4; p++) dcnt[p] = 0;
        reqb = 4'b1010;
        tick;
        chk("s_grant3", grantb, 4'b1000);
        reqb = 4'b1110;
        repeat (3) tick;
        tick;
        chk("s_done3", doneb, 4'b1000);
        reqb = 4'b0110;
        tick;
        chk("s_grant1", grantb, 4'b0010);
        repeat (3) tick;
        tick;
        chk("s_done1", doneb, 4'b0010);
        reqb = 4'b0100;
        tick;
        chk("s_grant2b", grantb, 4'b0100);
        repeat (3) tick;
        tick;
        chk("s_done2b", doneb, 4'b0100);
        reqb = '0;
        tick;
        chk("s_cnt0", dcnt[0], 0);
        chk("s_cnt1", dcnt[1], 1);
        chk("s_cnt2", dcnt[2], 1);
        chk("s_cnt3", dcnt[3], 1);
        // asynchronous reset in the middle of an access
        for (int p = 0; p < 4; p++) dcnt[p] = 0;
        reqb = 4'b0001;
        tick;
        chk("r_grant", grantb, 4'b0001);
        tick;
        chk("r_cnt_mid", cntb, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("r_ready", readyb, 1);
        chk("r_grant0", grantb, 0);
        chk("r_cnt0", cntb, 0);
        chk("r_done0", doneb, 0);
        tick;
        chk("r_held_grant", grantb, 0);
        reqb = '0;
        rst_n = 1'b1;
        repeat (6) tick;
        chk("r_no_done", dcnt[0], 0);
        reqc = 2'b11;
        tick;
        chk("r_ptr_port0", grantc, 2'b01);
        reqc = '0;
        repeat (4) tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
